// File: rtl/ts_sync_framer.sv
`default_nettype none
// ============================================================================
// Module   : ts_sync_framer
// Purpose  : Aligns a raw byte stream to 204-byte transport packets using the
//            0x47/0xB8 sync bytes. It confirms lock over several packets,
//            flywheels over isolated sync errors, and forwards whole aligned
//            packets downstream over a rdy/acpt handshake.
// Revision : 1.0  initial release
// ============================================================================
module ts_sync_framer #(
    parameter int PKT_LEN    = 204,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] di,
    input  logic       di_rdy,
    output logic       di_acpt,
    output logic [7:0] do_data,
    output logic       do_rdy,
    input  logic       do_acpt,
    output logic       do_sop,
    output logic       do_err,
    output logic       locked,
    output logic [7:0] sync_loss_cnt
);

    localparam logic [7:0] c_LAST_POS   = 8'(PKT_LEN - 1);
    localparam logic [7:0] c_LOCK_CNT   = 8'(LOCK_CNT);
    localparam logic [7:0] c_UNLOCK_CNT = 8'(UNLOCK_CNT);
    localparam logic [7:0] c_SYNC_A     = 8'h47;
    localparam logic [7:0] c_SYNC_B     = 8'hB8;

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCK   = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_pos, w_pos_nxt;
    logic [7:0] r_good, w_good_nxt;
    logic [7:0] r_miss, w_miss_nxt;
    logic [7:0] r_loss_cnt;
    logic [7:0] r_do_data;
    logic       r_do_rdy, r_do_sop, r_do_err;

    logic       w_in_xfer, w_out_xfer, w_is_sync;
    logic [7:0] w_pos_inc;
    logic       w_fwd, w_fwd_sop, w_fwd_err, w_loss_inc;
    logic [7:0] w_fwd_data;

    // A new byte may enter whenever the output register is empty or draining.
    assign di_acpt    = !r_do_rdy | do_acpt;
    assign w_in_xfer  = di_rdy & di_acpt;
    assign w_out_xfer = r_do_rdy & do_acpt;
    assign w_is_sync  = (di == c_SYNC_A) || (di == c_SYNC_B);
    assign w_pos_inc  = (r_pos == c_LAST_POS) ? 8'd0 : r_pos + 8'd1;

    assign do_data       = r_do_data;
    assign do_rdy        = r_do_rdy;
    assign do_sop        = r_do_sop;
    assign do_err        = r_do_err;
    assign locked        = (r_state == S_LOCK);
    assign sync_loss_cnt = r_loss_cnt;

    // State, alignment and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_HUNT;
            r_pos   <= 8'd0;
            r_good  <= 8'd0;
            r_miss  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_good  <= w_good_nxt;
            r_miss  <= w_miss_nxt;
        end
    end

    // Next-state logic and forwarding decision for the byte being accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        w_fwd       = 1'b0;
        w_fwd_data  = di;
        w_fwd_sop   = 1'b0;
        w_fwd_err   = 1'b0;
        w_loss_inc  = 1'b0;
        if (w_in_xfer) begin
            case (r_state)
                S_HUNT: begin
                    if (w_is_sync) begin
                        w_good_nxt = 8'd1;
                        w_pos_nxt  = 8'd1;
                        if (c_LOCK_CNT == 8'd1) begin
                            w_state_nxt = S_LOCK;
                            w_miss_nxt  = 8'd0;
                            w_fwd       = 1'b1;
                            w_fwd_sop   = 1'b1;
                        end else begin
                            w_state_nxt = S_VERIFY;
                        end
                    end
                end
                S_VERIFY: begin
                    w_pos_nxt = w_pos_inc;
                    if (r_pos == 8'd0) begin
                        if (w_is_sync) begin
                            w_good_nxt = r_good + 8'd1;
                            if (r_good + 8'd1 == c_LOCK_CNT) begin
                                w_state_nxt = S_LOCK;
                                w_miss_nxt  = 8'd0;
                                w_fwd       = 1'b1;
                                w_fwd_sop   = 1'b1;
                            end
                        end else begin
                            // Alignment guess was wrong; the byte is not re-examined.
                            w_state_nxt = S_HUNT;
                            w_good_nxt  = 8'd0;
                            w_pos_nxt   = 8'd0;
                        end
                    end
                end
                S_LOCK: begin
                    w_pos_nxt = w_pos_inc;
                    w_fwd     = 1'b1;
                    if (r_pos == 8'd0) begin
                        w_fwd_sop = 1'b1;
                        if (w_is_sync) begin
                            w_miss_nxt = 8'd0;
                        end else if (r_miss + 8'd1 < c_UNLOCK_CNT) begin
                            // Flywheel: substitute a clean sync and flag it.
                            w_miss_nxt = r_miss + 8'd1;
                            w_fwd_data = c_SYNC_A;
                            w_fwd_err  = 1'b1;
                        end else begin
                            // Too many misses: drop at the boundary so no partial packet leaves.
                            w_fwd       = 1'b0;
                            w_fwd_sop   = 1'b0;
                            w_state_nxt = S_HUNT;
                            w_good_nxt  = 8'd0;
                            w_miss_nxt  = 8'd0;
                            w_pos_nxt   = 8'd0;
                            w_loss_inc  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_HUNT;
                    w_pos_nxt   = 8'd0;
                    w_good_nxt  = 8'd0;
                    w_miss_nxt  = 8'd0;
                end
            endcase
        end
    end

    // Output register: load on a forwarded byte, otherwise empty on handoff.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_do_data <= 8'h00;
            r_do_rdy  <= 1'b0;
            r_do_sop  <= 1'b0;
            r_do_err  <= 1'b0;
        end else if (w_fwd) begin
            r_do_data <= w_fwd_data;
            r_do_rdy  <= 1'b1;
            r_do_sop  <= w_fwd_sop;
            r_do_err  <= w_fwd_err;
        end else if (w_out_xfer) begin
            r_do_rdy  <= 1'b0;
        end
    end

    // Saturating count of lock losses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_loss_cnt <= 8'd0;
        end else if (w_loss_inc && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ts_sync_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ts_sync_framer
// Purpose  : Directed, scoreboard-checked bench for ts_sync_framer.
// Revision : 1.0  initial release
// ============================================================================
module tb_ts_sync_framer;

    localparam int PKT = 204;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] di;
    logic       di_rdy;
    logic       di_acpt;
    logic [7:0] do_data;
    logic       do_rdy;
    logic       do_acpt;
    logic       do_sop;
    logic       do_err;
    logic       locked;
    logic [7:0] sync_loss_cnt;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   bp_mode = 1'b0;
    int   bp_cnt = 0;

    ts_sync_framer #(.PKT_LEN(PKT), .LOCK_CNT(3), .UNLOCK_CNT(3)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .di            (di),
        .di_rdy        (di_rdy),
        .di_acpt       (di_acpt),
        .do_data       (do_data),
        .do_rdy        (do_rdy),
        .do_acpt       (do_acpt),
        .do_sop        (do_sop),
        .do_err        (do_err),
        .locked        (locked),
        .sync_loss_cnt (sync_loss_cnt)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream acceptance: always ready, or one cycle in three when stalling.
    initial begin
        do_acpt = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bp_cnt++;
                do_acpt = (bp_cnt % 3 == 0);
            end else begin
                do_acpt = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each output handoff and checks stall behaviour.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && do_rdy === 1'b1) begin
                if (!do_acpt) check("di_acpt_stall", {31'd0, di_acpt}, 32'd0);
                if (do_acpt) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got data 0x%0h sop %0b, expected nothing", do_data, do_sop);
                    end else begin
                        e = q.pop_front();
                        check("out_byte", {22'd0, do_data, do_sop, do_err}, {22'd0, e.data, e.sop, e.err});
                    end
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic send_byte(input logic [7:0] b, input bit fwd, input exp_t e);
        bit acc;
        int budget;
        if (bp_mode) begin
            while ($urandom_range(0, 1) == 1) begin
                di_rdy = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        di     = b;
        di_rdy = 1'b1;
        acc    = 1'b0;
        budget = 0;
        while (!acc) begin
            @(negedge clk);
            acc = di_acpt;
            @(posedge clk);
            #1;
            budget++;
            if (!acc && budget > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got di_acpt 0, required 1 within 50 cycles");
                break;
            end
        end
        if (acc && fwd) q.push_back(e);
    endtask

    // Sends bytes [first, last) of a packet; safe payload avoids sync values.
    task automatic send_pkt(input logic [7:0] sync, input bit safe, input bit fwd,
                            input bit sub, input int first, input int last);
        logic [7:0] b;
        exp_t       e;
        for (int i = first; i < last; i++) begin
            if (i == 0) b = sync;
            else        b = safe ? 8'(i % 64) : 8'(i);
            e.data = (i == 0 && sub) ? 8'h47 : b;
            e.sop  = (i == 0);
            e.err  = (i == 0) && sub;
            send_byte(b, fwd, e);
        end
        di_rdy = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        di_rdy = 1'b0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain", q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        di_rdy  = 1'b0;
        di      = 8'h00;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t dummy;
        dummy   = '0;
        di      = 8'h00;
        di_rdy  = 1'b0;
        reset_n = 1'b0;
        #1;
        do_reset();

        // Reset state
        check("rst_do_rdy", {31'd0, do_rdy}, 32'd0);
        check("rst_do_sop", {31'd0, do_sop}, 32'd0);
        check("rst_do_err", {31'd0, do_err}, 32'd0);
        check("rst_do_data", {24'd0, do_data}, 32'h00);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_loss", {24'd0, sync_loss_cnt}, 32'd0);
        check("rst_di_acpt", {31'd0, di_acpt}, 32'd1);

        // Clean stream: packets 1-2 discarded, 3-4 forwarded.
        send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 0, PKT);
        check("t1_locked_pre", {31'd0, locked}, 32'd0);
        send_pkt(8'h47, 1'b0, 1'b1, 1'b0, 0, 1);
        check("t1_locked_rise", {31'd0, locked}, 32'd1);
        send_pkt(8'h47, 1'b0, 1'b1, 1'b0, 1, PKT);
        send_pkt(8'h47, 1'b0, 1'b1, 1'b0, 0, PKT);
        drain();

        // Garbage prefix, alternating sync values.
        do_reset();
        for (int i = 0; i < 37; i++) send_byte(8'h00, 1'b0, dummy);
        send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 0, PKT);
        send_pkt(8'hB8, 1'b0, 1'b0, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b0, 1'b1, 1'b0, 0, PKT);
        send_pkt(8'hB8, 1'b0, 1'b1, 1'b0, 0, PKT);
        drain();
        check("t2_locked", {31'd0, locked}, 32'd1);

        // Single missed sync is flywheeled.
        do_reset();
        send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b0, 1'b1, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b0, 1'b1, 1'b0, 0, PKT);
        send_pkt(8'h00, 1'b0, 1'b1, 1'b1, 0, PKT);
        check("t3_locked_after_miss", {31'd0, locked}, 32'd1);
        send_pkt(8'h47, 1'b0, 1'b1, 1'b0, 0, PKT);
        drain();
        check("t3_loss", {24'd0, sync_loss_cnt}, 32'd0);
        check("t3_locked", {31'd0, locked}, 32'd1);

        // Three consecutive misses force HUNT; relock on the 3rd good packet.
        do_reset();
        send_pkt(8'h47, 1'b1, 1'b0, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b1, 1'b0, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b1, 1'b1, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b1, 1'b1, 1'b0, 0, PKT);
        send_pkt(8'h00, 1'b1, 1'b1, 1'b1, 0, PKT);
        send_pkt(8'h00, 1'b1, 1'b1, 1'b1, 0, PKT);
        send_pkt(8'h00, 1'b1, 1'b0, 1'b0, 0, 1);
        check("t4_unlocked", {31'd0, locked}, 32'd0);
        check("t4_loss", {24'd0, sync_loss_cnt}, 32'd1);
        send_pkt(8'h00, 1'b1, 1'b0, 1'b0, 1, PKT);
        send_pkt(8'h47, 1'b1, 1'b0, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b1, 1'b0, 1'b0, 0, PKT);
        check("t4_still_unlocked", {31'd0, locked}, 32'd0);
        send_pkt(8'h47, 1'b1, 1'b1, 1'b0, 0, PKT);
        drain();
        check("t4_relocked", {31'd0, locked}, 32'd1);
        check("t4_loss_end", {24'd0, sync_loss_cnt}, 32'd1);

        // Backpressure with random upstream gaps.
        do_reset();
        bp_mode = 1'b1;
        send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b0, 1'b1, 1'b0, 0, PKT);
        send_pkt(8'h00, 1'b0, 1'b1, 1'b1, 0, PKT);
        send_pkt(8'hB8, 1'b0, 1'b1, 1'b0, 0, PKT);
        drain();
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-packet while locked.
        do_reset();
        send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b0, 1'b1, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b0, 1'b1, 1'b0, 0, 100);
        check("t6_rdy_before", {31'd0, do_rdy}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_rdy_async", {31'd0, do_rdy}, 32'd0);
        check("t6_locked_async", {31'd0, locked}, 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 0, PKT);
        send_pkt(8'h47, 1'b0, 1'b0, 1'b0, 0, PKT);
        check("t6_relock_pre", {31'd0, locked}, 32'd0);
        send_pkt(8'h47, 1'b0, 1'b1, 1'b0, 0, 1);
        check("t6_relock", {31'd0, locked}, 32'd1);
        send_pkt(8'h47, 1'b0, 1'b1, 1'b0, 1, PKT);
        drain();
        check("t6_loss", {24'd0, sync_loss_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
